// File: rtl/sysid_checker_pkg.sv
// rtl/sysid_checker_pkg.sv - shared state, fail-code and address definitions for sysid_checker
package sysid_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ID_REQ  = 3'd1,
    ST_ID_WAIT = 3'd2,
    ST_TS_REQ  = 3'd3,
    ST_TS_WAIT = 3'd4,
    ST_CHECK   = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  localparam logic [1:0] FAIL_NONE    = 2'd0;
  localparam logic [1:0] FAIL_ID      = 2'd1;
  localparam logic [1:0] FAIL_TS      = 2'd2;
  localparam logic [1:0] FAIL_TIMEOUT = 2'd3;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // States in which a read attempt is outstanding and the timeout runs.
  function automatic logic is_bus_state(input state_t s);
    return (s == ST_ID_REQ) || (s == ST_ID_WAIT) ||
           (s == ST_TS_REQ) || (s == ST_TS_WAIT);
  endfunction

endpackage

// File: rtl/sysid_timeout_counter.sv
// rtl/sysid_timeout_counter.sv - per-attempt cycle counter with terminal-count flag
// Ports:
//   i_clock     system clock
//   i_reset_n   synchronous active-low reset
//   i_clear     restart the count (entry to a request state)
//   i_enable    count this cycle (attempt in progress)
//   o_terminal  this is the last cycle of the attempt window
module sysid_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  // Count starts at 0 in the first cycle of an attempt, so the attempt
  // lasts exactly TIMEOUT_CYCLES cycles.
  localparam logic [15:0] LP_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_count;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_terminal = i_enable && (r_count == LP_LAST);

endmodule

// File: rtl/sysid_checker.sv
// rtl/sysid_checker.sv - reads sysid ID/timestamp words and checks them against expected values
// Ports:
//   clock, reset_n            system clock, synchronous active-low reset
//   start                     pulse: begin a check from IDLE or DONE
//   avm_*                     Avalon-MM read master towards the sysid slave
//   busy, done, pass          check status (done is a level held until next start)
//   fail_code                 0 none, 1 ID mismatch, 2 timestamp mismatch, 3 timeout
//   id_value, timestamp_value last captured words
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1392009444,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter int          MAX_RETRIES        = 3,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  fail_code,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value
);

  localparam logic [3:0] LP_MAX_RETRIES = 4'(MAX_RETRIES);

  state_t      r_state, w_next_state;
  logic        r_first;
  logic [3:0]  r_retry;
  logic        w_terminal, w_timeout, w_retry_ok;
  logic        w_enter_req, w_clear_retry, w_retry_inc, w_timeout_fail;
  state_t      w_req_state;

  logic        r_avm_read, r_avm_address, r_busy, r_done, r_pass;
  logic [1:0]  r_fail_code;
  logic [31:0] r_id_value, r_ts_value;
  logic        w_read_nxt, w_addr_nxt, w_busy_nxt, w_done_nxt, w_pass_nxt;
  logic [1:0]  w_fail_nxt;
  logic [31:0] w_id_nxt, w_ts_nxt;

  sysid_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .i_clock    (clock),
    .i_reset_n  (reset_n),
    .i_clear    (w_enter_req),
    .i_enable   (is_bus_state(r_state)),
    .o_terminal (w_terminal)
  );

  // r_first marks the first cycle after reset release for auto-start.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_first <= 1'b1;
      r_retry <= '0;
    end else begin
      r_state <= w_next_state;
      r_first <= 1'b0;
      if (w_clear_retry) begin
        r_retry <= '0;
      end else if (w_retry_inc) begin
        r_retry <= r_retry + 4'd1;
      end
    end
  end

  assign w_retry_ok  = (r_retry < LP_MAX_RETRIES);
  assign w_req_state = ((r_state == ST_ID_REQ) || (r_state == ST_ID_WAIT)) ? ST_ID_REQ : ST_TS_REQ;

  always_comb begin
    w_next_state   = r_state;
    w_enter_req    = 1'b0;
    w_clear_retry  = 1'b0;
    w_retry_inc    = 1'b0;
    w_timeout_fail = 1'b0;
    w_timeout      = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start || (r_state == ST_IDLE && AUTO_START && r_first)) begin
          w_next_state  = ST_ID_REQ;
          w_enter_req   = 1'b1;
          w_clear_retry = 1'b1;
        end
      end
      // In a request state the timeout beats a same-cycle acceptance.
      ST_ID_REQ, ST_TS_REQ: begin
        if (w_terminal) begin
          w_timeout = 1'b1;
        end else if (!avm_waitrequest) begin
          w_next_state = (r_state == ST_ID_REQ) ? ST_ID_WAIT : ST_TS_WAIT;
        end
      end
      // In a wait state arriving data beats a same-cycle timeout.
      ST_ID_WAIT: begin
        if (avm_readdatavalid) begin
          w_next_state = ST_TS_REQ;
          w_enter_req  = 1'b1;
        end else if (w_terminal) begin
          w_timeout = 1'b1;
        end
      end
      ST_TS_WAIT: begin
        if (avm_readdatavalid) begin
          w_next_state = ST_CHECK;
        end else if (w_terminal) begin
          w_timeout = 1'b1;
        end
      end
      ST_CHECK: w_next_state = ST_DONE;
      default:  w_next_state = ST_IDLE;
    endcase
    if (w_timeout) begin
      if (w_retry_ok) begin
        w_next_state = w_req_state;
        w_enter_req  = 1'b1;
        w_retry_inc  = 1'b1;
      end else begin
        w_next_state   = ST_DONE;
        w_timeout_fail = 1'b1;
      end
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    w_read_nxt = (w_next_state == ST_ID_REQ) || (w_next_state == ST_TS_REQ);
    w_addr_nxt = r_avm_address;
    if (w_next_state == ST_ID_REQ) begin
      w_addr_nxt = SYSID_ADDR_ID;
    end else if (w_next_state == ST_TS_REQ) begin
      w_addr_nxt = SYSID_ADDR_TS;
    end
    w_busy_nxt = (w_next_state != ST_IDLE) && (w_next_state != ST_DONE);
    w_done_nxt = (w_next_state == ST_DONE);
    w_pass_nxt = r_pass;
    w_fail_nxt = r_fail_code;
    if (w_clear_retry) begin
      w_pass_nxt = 1'b0;
      w_fail_nxt = FAIL_NONE;
    end
    if (r_state == ST_CHECK) begin
      if (r_id_value != EXPECTED_ID) begin
        w_fail_nxt = FAIL_ID;
      end else if (r_ts_value != EXPECTED_TIMESTAMP) begin
        w_fail_nxt = FAIL_TS;
      end else begin
        w_pass_nxt = 1'b1;
      end
    end
    if (w_timeout_fail) begin
      w_fail_nxt = FAIL_TIMEOUT;
      w_pass_nxt = 1'b0;
    end
    w_id_nxt = r_id_value;
    w_ts_nxt = r_ts_value;
    if (avm_readdatavalid && r_state == ST_ID_WAIT) begin
      w_id_nxt = avm_readdata;
    end
    if (avm_readdatavalid && r_state == ST_TS_WAIT) begin
      w_ts_nxt = avm_readdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_avm_read    <= 1'b0;
      r_avm_address <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_fail_code   <= FAIL_NONE;
      r_id_value    <= '0;
      r_ts_value    <= '0;
    end else begin
      r_avm_read    <= w_read_nxt;
      r_avm_address <= w_addr_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
      r_pass        <= w_pass_nxt;
      r_fail_code   <= w_fail_nxt;
      r_id_value    <= w_id_nxt;
      r_ts_value    <= w_ts_nxt;
    end
  end

  assign avm_read        = r_avm_read;
  assign avm_address     = r_avm_address;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign fail_code       = r_fail_code;
  assign id_value        = r_id_value;
  assign timestamp_value = r_ts_value;

endmodule

// File: doc/sysid_checker.md
# sysid_checker

Avalon-MM read master that sits directly upstream of the system-ID slave in the de2i_150 Qsys system. After reset (or on a `start` pulse) it reads the slave's ID word (word address 0) and build-timestamp word (word address 1), then compares both against expected constants. It reports pass/fail flags and the captured values to the host-visible status logic, so mismatched FPGA images and software builds are caught before the rest of the system is enabled.

## Interface
Parameters:
- `EXPECTED_ID`, 32'd0, value required at word address 0
- `EXPECTED_TIMESTAMP`, 32'd1392009444, value required at word address 1
- `TIMEOUT_CYCLES`, 255, max cycles per read attempt (request + response); range 2..65535
- `MAX_RETRIES`, 3, re-attempts of a timed-out read before failing; range 0..15
- `AUTO_START`, 1, 1 = begin a check automatically on the first cycle after reset release

Ports:
- `clock`  in  1  single system clock; all logic rising-edge
- `reset_n`  in  1  synchronous, active-low reset
- `start`  in  1  pulse; starts a new check when in IDLE or DONE, ignored otherwise
- `avm_address`  out  1  word address to sysid slave
- `avm_read`  out  1  read request
- `avm_waitrequest`  in  1  slave stall
- `avm_readdata`  in  32  read data
- `avm_readdatavalid`  in  1  response strobe
- `busy`  out  1  check in progress
- `done`  out  1  level; check finished, held until next start
- `pass`  out  1  valid when `done`; both words matched
- `fail_code`  out  2  0 none, 1 ID mismatch, 2 timestamp mismatch, 3 timeout
- `id_value`  out  32  last captured ID word
- `timestamp_value`  out  32  last captured timestamp word

## Operation
- States: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, CHECK, DONE.
- Reset (sampled `reset_n`=0): state IDLE, all outputs 0, timeout and retry counters 0.
- IDLE: goes to ID_REQ if `start`=1 or (`AUTO_START`=1 and first cycle after reset release).
- ID_REQ: `avm_read`=1, `avm_address`=0. The address is held while `avm_waitrequest`=1. The first cycle with waitrequest=0 is acceptance; the next state is ID_WAIT.
- ID_WAIT: `avm_read`=0. `avm_readdatavalid`=1 loads `id_value`, and the next state is TS_REQ.
- TS_REQ/TS_WAIT: identical to the ID pair with `avm_address`=1. Data loads `timestamp_value`, and the next state is CHECK.
- CHECK (1 cycle): if the ID differs, `fail_code`=1. Otherwise, if the timestamp differs, `fail_code`=2. Otherwise `pass`=1. The next state is DONE.
- DONE: `done`=1, results held. A `start` pulse clears `done`, `pass` and `fail_code` and goes to ID_REQ. Captured values are kept until overwritten.
- Timeout: a counter clears on entry to each REQ state and increments every cycle in REQ/WAIT. On reaching `TIMEOUT_CYCLES`:
  - If retries < `MAX_RETRIES`: increment retries and re-enter the same REQ state.
  - Else: `fail_code`=3, `pass`=0, go to DONE.
  - The retry counter clears on entry to ID_REQ from IDLE/DONE only.
- `readdatavalid` is ignored outside WAIT states, including late responses to a timed-out read.
- `start` while busy is ignored.
- `busy`=1 in every state except IDLE and DONE.

## Timing
- All outputs are registered. `avm_read` rises the cycle after the IDLE→ID_REQ decision.
- Acceptance occurs in the cycle where `avm_read`=1 and waitrequest=0. `avm_read` is 0 in the following cycle.
- The fabric supplies read latency ≥1. The earliest `readdatavalid` is the cycle after acceptance.
- Best case, zero waitrequest and latency 1: start at cycle 0, ID_REQ at cycle 1, ID data at cycle 2, TS_REQ at cycle 3, TS data at cycle 4, CHECK at cycle 5, `done`=1 at cycle 6.
- Simultaneous timeout terminal count and `readdatavalid` in a WAIT state: the data wins; there is no retry.
- `reset_n`=0 mid-transaction: IDLE next cycle and `avm_read`=0 immediately, with no bus cleanup. With `AUTO_START`=1 the check restarts after release.

## Structure
- Shared package `sysid_checker_pkg`: state enum (7 states, 3-bit), fail-code constants `FAIL_NONE/FAIL_ID/FAIL_TS/FAIL_TIMEOUT`, and address constants `SYSID_ADDR_ID`=0 and `SYSID_ADDR_TS`=1.
- One sub-module, `sysid_timeout_counter`, contains the clear/enable counter with a terminal-count flag, parameterised by `TIMEOUT_CYCLES`. The FSM, retry counter and result registers stay in the top module.

## Test plan
- Slave model returns 0 and 1392009444, no waitrequest, latency 1, `AUTO_START`=1 → `done`=1 at cycle 6 after release, `pass`=1, `fail_code`=0, `timestamp_value`=1392009444.
- Slave returns 32'h1 at address 0 → `pass`=0, `fail_code`=1, `id_value`=1, and the timestamp read still occurs.
- Waitrequest is held for 5 cycles on each read and latency is 3 → address is stable during stall, `avm_read` is one cycle past acceptance, and the result is pass.
- `readdatavalid` is never asserted, with `TIMEOUT_CYCLES`=10 and `MAX_RETRIES`=2 → 3 ID_REQ attempts, then `fail_code`=3 and `done`=1 about 30 cycles after start.
- `reset_n` is driven low while in TS_WAIT, then released with `AUTO_START`=0 → outputs 0, stays IDLE. A later `start` pulse gives a full pass, and a `start` pulse during busy is ignored.
